// File: rtl/fb_scanout.sv
// ---------------------------------------------------------------------------
// fb_scanout
//   Raster scanout engine. Walks a horizontal/vertical timing grid, issues
//   framebuffer read addresses for the visible area, and emits registered
//   RGB888 pixels with matching sync and data-enable signals. A frame that
//   has started always runs to its end, even if enable drops part-way.
//
// Ports
//   clk          in   1   single clock, everything updates on the rising edge
//   rst          in   1   synchronous, active-high reset
//   enable       in   1   scanout permitted (from the rasterizer write_done)
//   fb_raddr     out  19  framebuffer read address (combinational)
//   fb_rdata     in   24  framebuffer read data, one cycle after fb_raddr
//   pixel        out  24  RGB888 pixel, black outside the active area
//   counterX     out  10  x of the pixel currently presented
//   counterY     out  10  y of the pixel currently presented
//   de           out  1   data enable, high for visible pixels
//   hsync        out  1   horizontal sync, active-low
//   vsync        out  1   vertical sync, active-low
//   frame_done   out  1   one-cycle pulse with the last pixel of a frame
//   frame_count  out  16  number of completed frames, wraps at 65535
// ---------------------------------------------------------------------------
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [18:0] fb_raddr,
    input  logic [23:0] fb_rdata,
    output logic [23:0] pixel,
    output logic [9:0]  counterX,
    output logic [9:0]  counterY,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [HW-1:0]   h_r;
    logic [HW-1:0]   h_nxt_s;
    logic [VW-1:0]   v_r;
    logic [VW-1:0]   v_nxt_s;

    logic            run_s;
    logic            h_last_s;
    logic            v_last_s;
    logic            active0_s;
    logic            hsync0_s;
    logic            vsync0_s;
    logic            frame_end0_s;

    logic            active_d1_r;
    logic            hsync_d1_r;
    logic            vsync_d1_r;
    logic            frame_end_d1_r;
    logic [HW-1:0]   h_d1_r;
    logic [VW-1:0]   v_d1_r;

    logic [23:0]     pixel_r;
    logic [9:0]      counter_x_r;
    logic [9:0]      counter_y_r;
    logic            de_r;
    logic            hsync_r;
    logic            vsync_r;
    logic            frame_done_r;
    logic [15:0]     frame_count_r;

    assign run_s    = (state_r == ST_RUN);
    assign h_last_s = (h_r == HW'(H_TOTAL - 1));
    assign v_last_s = (v_r == VW'(V_TOTAL - 1));

    // State and raster counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            h_r     <= '0;
            v_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            h_r     <= h_nxt_s;
            v_r     <= v_nxt_s;
        end
    end

    // Next-state and counter advance; leaving RUN only at the frame boundary
    always_comb begin
        state_nxt_s = state_r;
        h_nxt_s     = h_r;
        v_nxt_s     = v_r;
        case (state_r)
            ST_IDLE: begin
                h_nxt_s = '0;
                v_nxt_s = '0;
                if (enable) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (h_last_s) begin
                    h_nxt_s = '0;
                    if (v_last_s) begin
                        v_nxt_s = '0;
                        if (enable) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        v_nxt_s = v_r + VW'(1'b1);
                    end
                end else begin
                    h_nxt_s = h_r + HW'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                h_nxt_s     = '0;
                v_nxt_s     = '0;
            end
        endcase
    end

    // Stage-0 decode of the raster position; everything inactive in IDLE
    always_comb begin
        active0_s    = run_s && (int'(h_r) < H_ACTIVE) && (int'(v_r) < V_ACTIVE);
        hsync0_s     = !(run_s && (int'(h_r) >= H_ACTIVE + H_FP)
                                && (int'(h_r) <  H_ACTIVE + H_FP + H_SYNC));
        vsync0_s     = !(run_s && (int'(v_r) >= V_ACTIVE + V_FP)
                                && (int'(v_r) <  V_ACTIVE + V_FP + V_SYNC));
        frame_end0_s = run_s && h_last_s && v_last_s;
        if (active0_s) begin
            // Row stride is the visible width; the peak value fits 19 bits
            fb_raddr = (19'(v_r) * 19'(H_ACTIVE)) + 19'(h_r);
        end else begin
            fb_raddr = 19'd0;
        end
    end

    // Stage 1: delay timing by one cycle to line up with fb_rdata
    always_ff @(posedge clk) begin
        if (rst) begin
            active_d1_r    <= 1'b0;
            hsync_d1_r     <= 1'b1;
            vsync_d1_r     <= 1'b1;
            frame_end_d1_r <= 1'b0;
            h_d1_r         <= '0;
            v_d1_r         <= '0;
        end else begin
            active_d1_r    <= active0_s;
            hsync_d1_r     <= hsync0_s;
            vsync_d1_r     <= vsync0_s;
            frame_end_d1_r <= frame_end0_s;
            h_d1_r         <= h_r;
            v_d1_r         <= v_r;
        end
    end

    // Stage 2: registered outputs, pixel blanked outside the active area
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_r       <= 24'h000000;
            counter_x_r   <= 10'd0;
            counter_y_r   <= 10'd0;
            de_r          <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            if (active_d1_r) begin
                pixel_r <= fb_rdata;
            end else begin
                pixel_r <= 24'h000000;
            end
            counter_x_r  <= 10'(h_d1_r);
            counter_y_r  <= 10'(v_d1_r);
            de_r         <= active_d1_r;
            hsync_r      <= hsync_d1_r;
            vsync_r      <= vsync_d1_r;
            frame_done_r <= frame_end_d1_r;
            if (frame_end_d1_r) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign pixel       = pixel_r;
    assign counterX    = counter_x_r;
    assign counterY    = counter_y_r;
    assign de          = de_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_fb_scanout.sv
// ---------------------------------------------------------------------------
// tb_fb_scanout
//   Directed bench. A reduced-timing instance (24x13 total, 16x8 visible)
//   is scanned pixel by pixel against hand-derived timing; a default-timing
//   instance covers the 640-wide address stride and line/hsync placement.
// ---------------------------------------------------------------------------
module tb_fb_scanout;

    // Reduced timing for the small instance
    localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int S_HT = 24, S_VT = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Small instance signals
    logic        s_rst, s_en;
    logic [18:0] s_raddr;
    logic [23:0] s_rdata;
    logic [23:0] s_pixel;
    logic [9:0]  s_cx, s_cy;
    logic        s_de, s_hs, s_vs, s_fd;
    logic [15:0] s_fc;

    // Default instance signals
    logic        f_rst, f_en;
    logic [18:0] f_raddr;
    logic [23:0] f_rdata;
    logic [23:0] f_pixel;
    logic [9:0]  f_cx, f_cy;
    logic        f_de, f_hs, f_vs, f_fd;
    logic [15:0] f_fc;

    fb_scanout #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) u_small (
        .clk(clk), .rst(s_rst), .enable(s_en),
        .fb_raddr(s_raddr), .fb_rdata(s_rdata), .pixel(s_pixel),
        .counterX(s_cx), .counterY(s_cy), .de(s_de),
        .hsync(s_hs), .vsync(s_vs), .frame_done(s_fd), .frame_count(s_fc)
    );

    fb_scanout u_full (
        .clk(clk), .rst(f_rst), .enable(f_en),
        .fb_raddr(f_raddr), .fb_rdata(f_rdata), .pixel(f_pixel),
        .counterX(f_cx), .counterY(f_cy), .de(f_de),
        .hsync(f_hs), .vsync(f_vs), .frame_done(f_fd), .frame_count(f_fc)
    );

    // Memory models: small one tags data so blanking gating is visible
    always @(posedge clk) begin
        s_rdata <= {5'b10100, s_raddr};
        f_rdata <= {5'b00000, f_raddr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_de_s(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_de && lat < 50);
    endtask

    task automatic wait_de_f(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!f_de && lat < 50);
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, " de"},     32'(s_de),    32'd0);
        chk({tag, " hsync"},  32'(s_hs),    32'd1);
        chk({tag, " vsync"},  32'(s_vs),    32'd1);
        chk({tag, " pixel"},  32'(s_pixel), 32'd0);
        chk({tag, " cx"},     32'(s_cx),    32'd0);
        chk({tag, " cy"},     32'(s_cy),    32'd0);
        chk({tag, " fdone"},  32'(s_fd),    32'd0);
        chk({tag, " fcount"}, 32'(s_fc),    32'd0);
    endtask

    // Scan one small frame; the current sample must already be output (0,0)
    task automatic scan_frame_s(input int drop_line, input int exp_fc);
        int de_cnt = 0;
        int fd_cnt = 0;
        for (int y = 0; y < S_VT; y++) begin
            for (int x = 0; x < S_HT; x++) begin
                logic e_de, e_hs, e_vs, e_fd;
                logic [31:0] e_px;
                if (!(x == 0 && y == 0)) tick();
                if (y == drop_line && x == 0) s_en = 1'b0;
                e_de = (x < S_HA) && (y < S_VA);
                e_hs = !((x >= S_HA + S_HFP) && (x < S_HA + S_HFP + S_HS));
                e_vs = !((y >= S_VA + S_VFP) && (y < S_VA + S_VFP + S_VS));
                e_fd = (x == S_HT - 1) && (y == S_VT - 1);
                e_px = e_de ? (32'h00A00000 | 32'(y * S_HA + x)) : 32'd0;
                chk("scan de",    32'(s_de),    32'(e_de));
                chk("scan hsync", 32'(s_hs),    32'(e_hs));
                chk("scan vsync", 32'(s_vs),    32'(e_vs));
                chk("scan cx",    32'(s_cx),    32'(x));
                chk("scan cy",    32'(s_cy),    32'(y));
                chk("scan pixel", 32'(s_pixel), e_px);
                chk("scan fdone", 32'(s_fd),    32'(e_fd));
                if (s_de) de_cnt++;
                if (s_fd) fd_cnt++;
            end
        end
        chk("frame de count",    32'(de_cnt), 32'(S_HA * S_VA));
        chk("frame fdone count", 32'(fd_cnt), 32'd1);
        chk("frame count",       32'(s_fc),   32'(exp_fc));
    endtask

    initial begin
        int lat;
        int line0, hs_low, hs_first, de_line0, it;
        logic done;

        s_rst = 1'b1; s_en = 1'b0;
        f_rst = 1'b1; f_en = 1'b0;
        repeat (3) tick();
        chk_reset_s("reset");
        chk("reset raddr", 32'(s_raddr), 32'd0);

        // Out of reset but not enabled: stays idle
        s_rst = 1'b0;
        repeat (3) tick();
        chk("idle de",    32'(s_de),    32'd0);
        chk("idle raddr", 32'(s_raddr), 32'd0);
        chk("idle hsync", 32'(s_hs),    32'd1);

        // Frame 1 full scan, enable held; output lags start by 3 edges
        s_en = 1'b1;
        wait_de_s(lat);
        chk("start latency", 32'(lat), 32'd3);
        scan_frame_s(-1, 1);

        // Frame 2 follows back to back; enable drops on line 3
        tick();
        scan_frame_s(3, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain de",    32'(s_de),    32'd0);
            chk("drain hsync", 32'(s_hs),    32'd1);
            chk("drain vsync", 32'(s_vs),    32'd1);
            chk("drain raddr", 32'(s_raddr), 32'd0);
            chk("drain pixel", 32'(s_pixel), 32'd0);
        end

        // Mid-frame reset with enable held at output (10,5)
        s_en = 1'b1;
        wait_de_s(lat);
        chk("restart latency", 32'(lat), 32'd3);
        repeat (5 * S_HT + 10) tick();
        chk("pre-reset cx", 32'(s_cx), 32'd10);
        chk("pre-reset cy", 32'(s_cy), 32'd5);
        s_rst = 1'b1;
        tick();
        chk_reset_s("midreset");
        s_rst = 1'b0;
        wait_de_s(lat);
        chk("post-reset latency", 32'(lat),     32'd3);
        chk("post-reset cx",      32'(s_cx),    32'd0);
        chk("post-reset cy",      32'(s_cy),    32'd0);
        chk("post-reset pixel",   32'(s_pixel), 32'h00A00000);

        // frame_count wrap: preload 65535, next frame_done wraps to 0
        force u_small.frame_count_r = 16'hFFFF;
        tick();
        release u_small.frame_count_r;
        tick();
        chk("preload fcount", 32'(s_fc), 32'h0000FFFF);
        it = 0;
        while (!s_fd && it < 400) begin
            tick();
            it++;
        end
        chk("wrap fdone seen", 32'(s_fd), 32'd1);
        chk("wrap fcount",     32'(s_fc), 32'd0);

        // Default-timing instance
        s_en = 1'b0;
        f_rst = 1'b0;
        tick();
        chk("full idle de",    32'(f_de), 32'd0);
        chk("full idle hsync", 32'(f_hs), 32'd1);
        f_en = 1'b1;
        wait_de_f(lat);
        chk("full latency",  32'(lat),     32'd3);
        chk("full first cx", 32'(f_cx),    32'd0);
        chk("full first cy", 32'(f_cy),    32'd0);
        chk("full first px", 32'(f_pixel), 32'd0);
        tick();
        chk("full second cx", 32'(f_cx),    32'd1);
        chk("full second px", 32'(f_pixel), 32'd1);

        line0 = 2; de_line0 = 2; hs_low = 0; hs_first = -1; done = 1'b0; it = 0;
        while (!done && it < 2500) begin
            tick();
            it++;
            if (f_cy == 10'd0) begin
                line0++;
                if (f_de) de_line0++;
                if (!f_hs) begin
                    if (hs_first < 0) hs_first = int'(f_cx);
                    hs_low++;
                end
            end
            if (f_cy == 10'd2 && f_cx == 10'd318) chk("full raddr (320,2)", 32'(f_raddr), 32'd1600);
            if (f_cy == 10'd2 && f_cx == 10'd320) begin
                chk("full pixel (320,2)", 32'(f_pixel), 32'd1600);
                done = 1'b1;
            end
        end
        chk("full reached (320,2)", 32'(done),     32'd1);
        chk("full line length",     32'(line0),    32'd800);
        chk("full line de count",   32'(de_line0), 32'd640);
        chk("full hsync start x",   32'(hs_first), 32'd656);
        chk("full hsync width",     32'(hs_low),   32'd96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
